// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - request FIFO and result register around an 8-bit combinational divider (optional macro DIV_ISSUE_DZ_FLAG_EN)

// Unsigned restoring divider; a zero divisor yields quot=8'hFF, mod=lop.
module CombDivider8 (
    input  logic [7:0] lop,
    input  logic [7:0] rop,
    output logic [7:0] quot,
    output logic [7:0] mod
);
    logic [8:0] rem;

    // Shift in one dividend bit per step and subtract the divisor when it fits.
    always_comb begin
        rem  = 9'd0;
        quot = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            rem = {rem[7:0], lop[i]};
            if (rem >= {1'b0, rop}) begin
                rem     = rem - {1'b0, rop};
                quot[i] = 1'b1;
            end
        end
        mod = rem[7:0];
    end
endmodule

module div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_lop,
    input  logic [7:0]               in_rop,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_quot,
    output logic [7:0]               out_mod,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_dz,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]       lop_mem_q [DEPTH];
    logic [7:0]       rop_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q;
    logic [7:0]       quot_q, mod_q;
    logic [TAG_W-1:0] tag_q;

    logic             accept, load;
    logic [7:0]       head_lop, head_rop, div_quot, div_mod;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign count     = count_q;
    assign accept    = in_valid && in_ready;
    // The result register takes a new head whenever it is empty or being drained.
    assign load      = (count_q != '0) && (!valid_q || out_ready);
    assign head_lop  = lop_mem_q[rd_ptr_q];
    assign head_rop  = rop_mem_q[rd_ptr_q];

    assign out_valid = valid_q;
    assign out_quot  = quot_q;
    assign out_mod   = mod_q;
    assign out_tag   = tag_q;

    CombDivider8 u_div (
        .lop  (head_lop),
        .rop  (head_rop),
        .quot (div_quot),
        .mod  (div_mod)
    );

    // Request storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lop_mem_q[wr_ptr_q] <= in_lop;
            rop_mem_q[wr_ptr_q] <= in_rop;
            tag_mem_q[wr_ptr_q] <= in_tag;
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({accept, load})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (load)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Result register: load from divider on pop, otherwise drop valid once consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            quot_q  <= '0;
            mod_q   <= '0;
            tag_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            quot_q  <= div_quot;
            mod_q   <= div_mod;
            tag_q   <= tag_mem_q[rd_ptr_q];
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef DIV_ISSUE_DZ_FLAG_EN
    logic dz_q;
    assign out_dz = dz_q;

    // Divide-by-zero flag travels with the result it describes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dz_q <= 1'b0;
        end else if (load) begin
            dz_q <= (head_rop == 8'd0);
        end
    end
`else
    assign out_dz = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_queue.sv
// tb/tb_div_issue_queue.sv - randomized and directed bench for div_issue_queue
module tb_div_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [7:0]       lop;
        logic [7:0]       rop;
        logic [TAG_W-1:0] tag;
    } req_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_lop = '0, in_rop = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic in_ready, out_valid, out_dz;
    logic [7:0] out_quot, out_mod;
    logic [TAG_W-1:0] out_tag;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending requests plus the held result.
    req_t       fifo_m[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_quot = '0, m_mod = '0;
    logic [TAG_W-1:0] m_tag = '0;
    logic       m_dz = 1'b0;

    div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lop(in_lop), .in_rop(in_rop), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_mod(out_mod), .out_tag(out_tag),
        .out_dz(out_dz), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit exp_dz(input logic [7:0] rop);
`ifdef DIV_ISSUE_DZ_FLAG_EN
        return rop == 8'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Model update at each clock edge, from the behavioural rules.
    always @(posedge clk or negedge reset_n) begin
        bit   acc, ld;
        req_t h, n;
        if (!reset_n) begin
            fifo_m.delete();
            m_valid <= 1'b0;
            m_quot  <= '0;
            m_mod   <= '0;
            m_tag   <= '0;
            m_dz    <= 1'b0;
        end else begin
            acc = in_valid && (fifo_m.size() < DEPTH);
            ld  = (fifo_m.size() != 0) && (!m_valid || out_ready);
            if (ld) begin
                h = fifo_m.pop_front();
                m_valid <= 1'b1;
                m_quot  <= (h.rop == 0) ? 8'hFF : 8'(h.lop / h.rop);
                m_mod   <= (h.rop == 0) ? h.lop : 8'(h.lop % h.rop);
                m_tag   <= h.tag;
                m_dz    <= exp_dz(h.rop);
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (acc) begin
                n.lop = in_lop; n.rop = in_rop; n.tag = in_tag;
                fifo_m.push_back(n);
            end
        end
    end

    // Compare DUT against the model midway through every cycle.
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(fifo_m.size() != DEPTH));
        chk("count", int'(count), fifo_m.size());
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_quot", int'(out_quot), int'(m_quot));
        chk("out_mod", int'(out_mod), int'(m_mod));
        chk("out_tag", int'(out_tag), int'(m_tag));
        chk("out_dz", int'(out_dz), int'(m_dz));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [7:0] l, input logic [7:0] r, input logic [TAG_W-1:0] t);
        in_valid = 1'b1; in_lop = l; in_rop = r; in_tag = t;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((fifo_m.size() != 0 || m_valid) && n < 100) begin
            step();
            n++;
        end
        chk("drain_bound", int'(n < 100), 1);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_quot", int'(out_quot), 0);
        reset_n = 1'b1;
        step();

        // Single request into idle block
        out_ready = 1'b1;
        set_req(8'd200, 8'd7, 4'd3);
        step();
        in_valid = 1'b0;
        chk("single_no_bypass", int'(out_valid), 0);
        chk("single_count1", int'(count), 1);
        step();
        chk("single_valid", int'(out_valid), 1);
        chk("single_quot", int'(out_quot), 28);
        chk("single_mod", int'(out_mod), 4);
        chk("single_tag", int'(out_tag), 3);
        chk("single_count0", int'(count), 0);
        step();
        chk("single_consumed", int'(out_valid), 0);

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            chk("stream_in_ready", int'(in_ready), 1);
            set_req(8'(i * 31), 8'(i + 1), 4'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stream_last_quot", int'(out_quot), 217 / 8);
        chk("stream_last_mod", int'(out_mod), 217 % 8);
        drain();

        // Fill with consumer stalled: one held plus DEPTH queued
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            set_req(8'(50 + i * 13), 8'(3 + i), 4'(8 + i));
            step();
        end
        set_req(8'd99, 8'd10, 4'd15);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_count", int'(count), DEPTH);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pulse_no_accept", int'(count), DEPTH - 1);
        chk("pulse_in_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("pulse_accept_next", int'(count), DEPTH);
        drain();

        // Divisor zero
        set_req(8'h5A, 8'h00, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        chk("dz_valid", int'(out_valid), 1);
        chk("dz_quot", int'(out_quot), 8'hFF);
        chk("dz_mod", int'(out_mod), 8'h5A);
        chk("dz_flag", int'(out_dz), int'(exp_dz(8'h00)));
        drain();

        // Reset mid-stream with 3 queued and a held result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(8'(20 + i), 8'd3, 4'(i));
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", int'(count), 3);
        chk("pre_rst_valid", int'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_quot", int'(out_quot), 0);
        chk("mid_rst_mod", int'(out_mod), 0);
        chk("mid_rst_tag", int'(out_tag), 0);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        set_req(8'd100, 8'd9, 4'd5);
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_quot", int'(out_quot), 11);
        chk("post_rst_mod", int'(out_mod), 1);
        chk("post_rst_tag", int'(out_tag), 5);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_lop    = 8'($urandom);
            in_rop    = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 40));
            in_tag    = TAG_W'($urandom);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
